// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    // One pipeline step walks IDLE -> (DATA) -> FETCH -> DONE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // addi x0, x0, 0 -- what the fetch buffer holds out of reset.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ready bus between the arbiter and the single-ported memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Arbiter side issues requests.
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    // Memory side answers them.
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes the data access and the instruction fetch of one pipeline step
// onto a single-ported memory, stalling the pipeline until both are done.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] PCF,
    output logic [DW-1:0] InstrF,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallMem,
    output logic [31:0]   StallCount,
    mem_arbiter_if.master mem
);

    arb_state_t state, state_next;

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          is_load;

    // A combined load+store behaves as a store, so it never fills the load buffer.
    assign is_load = MemReadM & ~MemWriteM;

    // Everything toward the memory comes from registered state; mem_ready
    // only steers the next state, never the current request.
    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;

    // The pipeline may only advance in the single DONE cycle.
    assign StallMem = (state != DONE);

    // State register; reset drops any in-flight request at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory-bus decode, data access before fetch.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        we         = 1'b0;
        addr       = '0;
        wdata      = '0;
        unique case (state)
            IDLE: begin
                state_next = (MemReadM | MemWriteM) ? DATA : FETCH;
            end
            DATA: begin
                req   = 1'b1;
                we    = MemWriteM;
                addr  = ALUResultM;
                wdata = WriteDataM;
                if (mem.mem_ready) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                req  = 1'b1;
                addr = PCF;
                if (mem.mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read buffers capture only on a completed access of the matching kind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            InstrF    <= DW'(NOP_INSTR);
            ReadDataM <= '0;
        end else begin
            if (state == DATA && mem.mem_ready && is_load) begin
                ReadDataM <= mem.mem_rdata;
            end
            if (state == FETCH && mem.mem_ready) begin
                InstrF <= mem.mem_rdata;
            end
        end
    end

    // Saturating count of stalled cycles for performance analysis.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            StallCount <= '0;
        end else if (StallMem && (StallCount != 32'hFFFF_FFFF)) begin
            StallCount <= StallCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: each pipeline step is expanded into the
// per-cycle outputs it must produce, and one process compares every cycle.
module tb_mem_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] PCF = '0;
    logic [31:0] InstrF;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic [31:0] StallCount;

    mem_arbiter_if #(.AW(32), .DW(32)) mif ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCF        (PCF),
        .InstrF     (InstrF),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .StallCount (StallCount),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic        stall;
        logic [31:0] instr;
        logic [31:0] rdata;
        logic [31:0] count;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_instr = NOP;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_count = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
        end
    endtask

    // Expected outputs for the current cycle, then account the stall.
    task automatic push(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic chk_wdata, input logic stall);
        exp_t e;
        e.req = req; e.we = we; e.addr = addr; e.wdata = wdata; e.chk_wdata = chk_wdata;
        e.stall = stall; e.instr = m_instr; e.rdata = m_rdata; e.count = m_count;
        exp_q.push_back(e);
        if (stall && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    endtask

    task automatic push_reset();
        m_instr = NOP;
        m_rdata = '0;
        m_count = '0;
        push(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        m_count = '0;
    endtask

    // One pipeline step. Memory answers after wd/wf wait cycles; abort_at>=0
    // asserts reset in that fetch cycle, with the memory still waiting.
    task automatic run_step(input bit rd, input bit wr, input logic [31:0] pc,
                            input logic [31:0] addr, input logic [31:0] wdat,
                            input int wd, input int wf, input logic [31:0] dval,
                            input logic [31:0] fval, input int abort_at, input bit preload);
        @(negedge clk);
        reset_n    = 1'b1;
        PCF        = pc;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = addr;
        WriteDataM = wdat;
        mif.mem_ready = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
        if (preload) begin
            force dut.StallCount = 32'hFFFF_FFFE;
            #1;
            release dut.StallCount;
            m_count = 32'hFFFF_FFFE;
        end
        push(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        if (rd || wr) begin
            for (int i = 0; i <= wd; i++) begin
                @(negedge clk);
                mif.mem_ready = (i == wd);
                mif.mem_rdata = (i == wd) ? dval : $urandom;
                push(1'b1, wr, addr, wdat, 1'b1, 1'b1);
            end
            if (rd && !wr) m_rdata = dval;
        end
        for (int i = 0; i <= wf; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                mif.mem_ready = 1'b0;
                push_reset();
                #1 reset_n = 1'b0;
                #1;
                chk("abort_req", {31'b0, mif.mem_req}, 32'd0);
                chk("abort_instr", InstrF, NOP);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    mif.mem_ready = 1'b1;
                    mif.mem_rdata = $urandom;
                    push_reset();
                end
                return;
            end
            mif.mem_ready = (i == wf);
            mif.mem_rdata = (i == wf) ? fval : $urandom;
            push(1'b1, 1'b0, pc, '0, 1'b0, 1'b1);
        end
        m_instr = fval;
        @(negedge clk);
        mif.mem_ready = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
        push(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    // Single compare process: every cycle has an expected record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mem_req", {31'b0, mif.mem_req}, {31'b0, e.req});
                chk("mem_we", {31'b0, mif.mem_we}, {31'b0, e.we});
                chk("mem_addr", mif.mem_addr, e.addr);
                if (e.chk_wdata) chk("mem_wdata", mif.mem_wdata, e.wdata);
                chk("StallMem", {31'b0, StallMem}, {31'b0, e.stall});
                chk("InstrF", InstrF, e.instr);
                chk("ReadDataM", ReadDataM, e.rdata);
                chk("StallCount", StallCount, e.count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit          rd, wr;
        logic [31:0] wdat_save;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mif.mem_ready = 1'b1;
            push_reset();
        end

        // Fetch-only, zero wait.
        run_step(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0050_0093, -1, 0);
        #4;
        chk("lit_fetch_instr", InstrF, 32'h0050_0093);
        chk("lit_fetch_count", StallCount, 32'd2);

        // Load then fetch, zero wait: 4-cycle step.
        run_step(1, 0, 32'h8, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 32'h0000_0113, -1, 0);
        #4;
        chk("lit_load_rdata", ReadDataM, 32'hDEAD_BEEF);
        chk("lit_load_count", StallCount, 32'd5);

        // Store with three wait cycles: 7-cycle step, load buffer untouched.
        run_step(0, 1, 32'hC, 32'h200, 32'h1234_5678, 3, 0, 32'hAAAA_5555, 32'h0000_0213, -1, 0);
        #4;
        chk("lit_store_rdata", ReadDataM, 32'hDEAD_BEEF);
        chk("lit_store_count", StallCount, 32'd11);

        // Load and store together act as a store.
        run_step(1, 1, 32'h10, 32'h300, 32'hCAFE_F00D, 1, 1, 32'h5555_AAAA, 32'h0000_0313, -1, 0);
        #4;
        chk("lit_both_rdata", ReadDataM, 32'hDEAD_BEEF);

        // Reset during a stalled fetch, then a normal step afterwards.
        run_step(0, 0, 32'h14, 32'h0, 32'h0, 0, 5, 32'h0, 32'h1111_1111, 2, 0);
        run_step(0, 0, 32'h18, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0000_0413, -1, 0);

        for (int n = 0; n < 60; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) == 0);
            wdat_save = $urandom;
            run_step(rd, wr, $urandom, $urandom, wdat_save,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom, $urandom, (n == 30) ? 1 : -1, 0);
        end

        // Counter saturation.
        run_step(0, 0, 32'h20, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0000_0513, -1, 1);
        #4;
        chk("lit_sat_count", StallCount, 32'hFFFF_FFFF);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified instruction/data memory between the Fetch stage (instruction read) and the Memory stage (load/store) of the 5-stage pipelined core. A four-state FSM serializes the two accesses per pipeline step, data first, using a req/ready handshake. It holds the whole pipeline via `StallMem` until every access the current step needs has completed. It also counts stall cycles for performance analysis.

## Interface
- `AW`, 32, address width
- `DW`, 32, data/instruction width
- `clk`  in  1  pipeline clock, rising edge
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `PCF`  in  AW  fetch address
- `InstrF`  out  DW  fetched instruction (buffered)
- `MemReadM`  in  1  load in Memory stage
- `MemWriteM`  in  1  store in Memory stage
- `ALUResultM`  in  AW  data address
- `WriteDataM`  in  DW  store data
- `ReadDataM`  out  DW  load data (buffered)
- `StallMem`  out  1  to Hazard Unit: freeze all pipeline registers this cycle
- `mem_req`  out  1  memory request, held until accepted
- `mem_we`  out  1  write enable, valid with `mem_req`
- `mem_addr`  out  AW  request address
- `mem_wdata`  out  DW  write data
- `mem_rdata`  in  DW  read data, valid when `mem_ready`=1
- `mem_ready`  in  1  completion pulse; earliest in the first cycle `mem_req`=1
- `StallCount`  out  32  saturating count of cycles with `StallMem`=1

## Operation
- States: IDLE, DATA, FETCH, DONE. Registered state.
- IDLE: if `MemReadM|MemWriteM`, go to DATA; else go to FETCH.
- DATA: `mem_req`=1, `mem_addr`=`ALUResultM`, `mem_we`=`MemWriteM`, `mem_wdata`=`WriteDataM`.
  - On `mem_ready`: if load, capture `mem_rdata` into the ReadDataM buffer; go to FETCH.
- FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=`PCF`.
  - On `mem_ready`: capture `mem_rdata` into the InstrF buffer; go to DONE.
- DONE: `StallMem`=0, so the pipeline advances at this edge; go to IDLE unconditionally.
- `StallMem` = (state != DONE). Pipeline inputs are stable while stalled.
- Outside DATA/FETCH: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- A store never updates the ReadDataM buffer. Buffers hold their value until the next capture.
- A simultaneous load and store (both asserted) is treated as a store.
- `StallCount` increments each cycle `StallMem`=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE
  - `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0
  - `InstrF`=32'h0000_0013 (NOP)
  - `ReadDataM`=0
  - `StallCount`=0
  - `StallMem`=1
- Reset mid-access: the request is dropped immediately. Any late `mem_ready` is ignored, since state is IDLE, which issues no request.
- Latency with zero-wait memory (`mem_ready` in the first request cycle):
  - fetch-only step: 3 cycles (IDLE, FETCH, DONE)
  - step with load/store: 4 cycles
- Each memory wait cycle adds exactly 1 cycle to the step.
- `mem_ready` while `mem_req`=0 is ignored.
- Outputs are derived from registered state only; there is no combinational path from `mem_ready` to `mem_req`.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, DATA, FETCH, DONE}
  - constant `NOP_INSTR` = 32'h0000_0013
- Single flat module, no sub-module; the stall counter is inline.

## Test plan
- Reset, then fetch-only with zero-wait memory, `PCF`=0x0, `mem_rdata`=0x00500093 → `mem_req` high 1 cycle at addr 0x0; `InstrF`=0x00500093; `StallMem` pattern 1,1,0 repeating; `StallCount`=2 after first step.
- Load, `ALUResultM`=0x100, data 0xDEADBEEF, then fetch `PCF`=0x8 → requests at 0x100 (we=0) then 0x8; `ReadDataM`=0xDEADBEEF; `StallMem` low exactly 1 cycle, 4 cycles after step start.
- Store, `ALUResultM`=0x200, `WriteDataM`=0x12345678, 3 wait cycles → `mem_we`=1 and `mem_addr`/`mem_wdata` stable for 4 cycles; `ReadDataM` unchanged; step length 7 cycles.
- Assert `reset_n`=0 during FETCH with the memory stalled → `mem_req`=0 immediately; `InstrF`=0x00000013; a spurious `mem_ready` after release causes no capture.
- Force the counter near saturation (32'hFFFF_FFFE), then stall 3 cycles → `StallCount` holds 32'hFFFF_FFFF.
